// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between four requesters and the shared output channel of rr_mux_arbiter.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         last;
    logic               out_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [3:0]         grant;
    logic [1:0]         sel;
    logic               busy;
    logic               timeout;

    modport master (
        output req, din, last, out_ready,
        input  out_valid, out_data, grant, sel, busy, timeout
    );

    modport slave (
        input  req, din, last, out_ready,
        output out_valid, out_data, grant, sel, busy, timeout
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin burst arbiter muxing four requesters onto one valid/ready channel.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD forced-release timeout.
module rr_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    rr_mux_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_mux_arbiter: MAX_HOLD must be within 2..255");
    end

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;

    logic [1:0] winner;
    logic       out_valid;
    logic       xfer;
    logic       rel_last;
    logic       rel_abandon;
    logic       force_rel;
    logic       release_now;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // First requester at or after ptr, scanning with 2-bit wrap; later offsets are overwritten.
    always_comb begin
        winner = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr_q + 2'(i)]) winner = ptr_q + 2'(i);
        end
    end

    assign out_valid     = (state_q == GRANT) & bus.req[sel_q];
    assign bus.out_valid = out_valid;
    assign bus.out_data  = (state_q == GRANT) ? bus.din[sel_q*WIDTH +: WIDTH] : '0;
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;

    assign xfer        = out_valid & bus.out_ready;
    assign rel_last    = xfer & bus.last[sel_q];
    assign rel_abandon = ~bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
    assign force_rel   = (hold_q == 8'(MAX_HOLD - 1)) & ~rel_last & ~rel_abandon;
    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign release_now = rel_last | rel_abandon | force_rel;

    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << winner;
                    sel_d   = winner;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
                if (release_now) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = sel_q + 2'd1;
                    busy_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = force_rel;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/pointer reference model.
module tb_rr_mux_arbiter;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the channel (-1 = nobody), where the scan starts, how long held.
    int       m_owner;
    int       m_ptr;
    int       m_sel;
    int       m_held;
    bit       m_timeout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_sel     = 0;
        m_held    = 0;
        m_timeout = 0;
    endtask

    task automatic compare_model();
        logic [3:0]       e_grant;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        e_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_valid = (m_owner >= 0) && bus.req[m_owner];
        e_data  = (m_owner >= 0) ? bus.din[m_owner*WIDTH +: WIDTH] : '0;
        check("m_grant",     32'(bus.grant),     32'(e_grant));
        check("m_sel",       32'(bus.sel),       32'(m_sel));
        check("m_busy",      32'(bus.busy),      32'(m_owner >= 0));
        check("m_timeout",   32'(bus.timeout),   32'(m_timeout));
        check("m_out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("m_out_data",  32'(bus.out_data),  32'(e_data));
    endtask

    task automatic model_update();
        bit done;
        bit forced;
        bit moved;
        if (rst) begin
            model_reset();
            return;
        end
        m_timeout = 0;
        if (m_owner < 0) begin
            moved = 0;
            for (int k = 0; k < 4; k++) begin
                if (!moved && bus.req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_held  = 0;
                    moved   = 1;
                end
            end
        end else begin
            done = (bus.req[m_owner] && bus.out_ready && bus.last[m_owner]) || !bus.req[m_owner];
`ifdef ARB_TIMEOUT_EN
            forced = !done && (m_held + 1 == MAX_HOLD);
`else
            forced = 0;
`endif
            if (done || forced) begin
                m_ptr     = (m_sel + 1) % 4;
                m_owner   = -1;
                m_timeout = forced;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                         input logic rdy, input logic [31:0] dn);
        @(negedge clk);
        rst           = r;
        bus.req       = rq;
        bus.last      = ls;
        bus.out_ready = rdy;
        bus.din       = dn;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        int               grants[$];
        logic [7:0]       bp_data [3];
        int               bp_rdy  [5];
        int               b;
        int               xfers;
        logic [3:0]       rq;
        logic [3:0]       ls;
        logic [31:0]      dn;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.req = '0; bus.last = '0; bus.out_ready = 1'b0; bus.din = '0;
        model_reset();

        // Reset state, then a single-beat grant to requester 2.
        drive(1, 4'h0, 4'h0, 0, 0); tick();
        drive(0, 4'h0, 4'h0, 1, 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_sel",   32'(bus.sel), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        tick();
        drive(0, 4'b0100, 4'b0100, 1, 32'h00A5_0000);
        check("arb_latency_busy", 32'(bus.busy), 0);
        tick();
        drive(0, 4'b0100, 4'b0100, 1, 32'h00A5_0000);
        check("t1_grant", 32'(bus.grant), 32'b0100);
        check("t1_sel",   32'(bus.sel), 2);
        check("t1_data",  32'(bus.out_data), 32'hA5);
        tick();
        drive(0, 4'hF, 4'h0, 0, 0);
        check("t1_release", 32'(bus.busy), 0);
        tick();
        drive(0, 4'hF, 4'h0, 0, 0);
        check("ptr_after_2", 32'(bus.grant), 32'b1000);
        tick();
        // Requester 3 abandons its burst.
        drive(0, 4'b0111, 4'h0, 0, 0);
        check("abandon_valid", 32'(bus.out_valid), 0);
        tick();
        drive(0, 4'h0, 4'h0, 0, 0);
        check("abandon_idle", 32'(bus.busy), 0);
        tick();

        // Fairness: everyone requesting, single-beat bursts.
        for (int c = 0; c < 10; c++) begin
            drive(0, 4'hF, 4'hF, 1, 32'h4433_2211);
            if (bus.busy) begin
                for (int i = 0; i < 4; i++) if (bus.grant[i]) grants.push_back(i);
            end
            tick();
        end
        check("fair_count", 32'(grants.size()), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("fair_order", 32'(grants[i]), 32'(i % 4));

        // Backpressure: 3-beat burst from requester 1 under toggling ready.
        bp_data = '{8'h11, 8'h22, 8'h33};
        bp_rdy  = '{1, 0, 1, 0, 1};
        drive(0, 4'b0010, 4'h0, 1, 0); tick();
        b = 0; xfers = 0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 4'b0010, (b == 2) ? 4'b0010 : 4'b0000, 1'(bp_rdy[c]), 32'(bp_data[b]) << 8);
            check("bp_busy", 32'(bus.busy), 1);
            if (bus.out_valid && bus.out_ready) begin
                check("bp_data", 32'(bus.out_data), 32'(bp_data[b]));
                xfers++;
                if (b < 2) b++;
            end
            tick();
        end
        drive(0, 4'h0, 4'h0, 0, 0);
        check("bp_released", 32'(bus.busy), 0);
        check("bp_xfers", 32'(xfers), 3);
        tick();

        // Hold without last: forced release only when the timeout is compiled in.
        drive(0, 4'b0011, 4'h0, 0, 0); tick();
        for (int c = 0; c < MAX_HOLD; c++) begin
            drive(0, 4'b0011, 4'h0, 0, 0);
            check("hold_busy", 32'(bus.busy), 1);
            tick();
        end
        drive(0, 4'b0011, 4'h0, 0, 0);
`ifdef ARB_TIMEOUT_EN
        check("to_pulse", 32'(bus.timeout), 1);
        check("to_idle",  32'(bus.busy), 0);
        tick();
        drive(0, 4'b0011, 4'h0, 0, 0);
        check("to_next_grant", 32'(bus.grant), 32'b0010);
        check("to_pulse_end",  32'(bus.timeout), 0);
`else
        check("no_to_grant", 32'(bus.grant), 32'b0001);
        check("no_to_pulse", 32'(bus.timeout), 0);
`endif
        tick();
        drive(0, 4'h0, 4'h0, 0, 0); tick();
        drive(0, 4'h0, 4'h0, 0, 0); tick();

        // Reset during the second beat of a burst.
        drive(0, 4'b0100, 4'h0, 1, 32'h0077_0000); tick();
        drive(0, 4'b0100, 4'h0, 1, 32'h0077_0000); tick();
        drive(1, 4'b0100, 4'h0, 1, 32'h0077_0000); tick();
        drive(0, 4'hF, 4'h0, 0, 32'h0077_0000);
        check("mid_rst_grant", 32'(bus.grant), 0);
        check("mid_rst_busy",  32'(bus.busy), 0);
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        tick();
        drive(0, 4'hF, 4'h0, 0, 0);
        check("mid_rst_ptr", 32'(bus.grant), 32'b0001);
        tick();

        // Randomized traffic with sticky requests and occasional reset.
        rq = 4'hF;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) rq[i] = ~rq[i];
            ls = 4'($urandom_range(15)) & 4'($urandom_range(15));
            dn = $urandom;
            drive(($urandom_range(149) == 0), rq, ls, ($urandom_range(3) != 0), dn);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
